// File: rtl/peak_bin_detect.sv
// ---------------------------------------------------------------------------
// peak_bin_detect
//   Scans channel-1 FFT bins LOBIN..HIBIN after each completed frame, finds
//   the bin with the largest squared magnitude (ties keep the lower bin) and
//   either announces it to the beamformer or reports that nothing cleared
//   the MINPWR threshold.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   synchronous, active-high reset
//   fftdone     in   1   pulse: FFT RAM 1 holds a complete new frame
//   ramq1       in  28   RAM 1 read data {re[13:0], im[13:0]}, signed,
//                        valid one cycle after rdaddr1
//   rdaddr1     out 10   RAM 1 read address (scan counter, or maxbin when done)
//   maxbin      out 10   bin of the last detected peak
//   peakpwr     out 28   squared magnitude at maxbin
//   detectdone  out  1   pulse: new maxbin/peakpwr valid, beamformer start
//   nosignal    out  1   pulse: scan finished with peak below MINPWR
// ---------------------------------------------------------------------------
module peak_bin_detect #(
    parameter logic [9:0]  LOBIN  = 10'd1,
    parameter logic [9:0]  HIBIN  = 10'd511,
    parameter logic [27:0] MINPWR = 28'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fftdone,
    input  logic [27:0] ramq1,
    output logic [9:0]  rdaddr1,
    output logic [9:0]  maxbin,
    output logic [27:0] peakpwr,
    output logic        detectdone,
    output logic        nosignal
);

    localparam int unsigned BIN_W  = 10;
    localparam int unsigned PWR_W  = 28;
    localparam int unsigned CMP_W  = 14;
    localparam int unsigned SQ_W   = 27;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SCAN     = 2'd1,
        S_DRAIN    = 2'd2,
        S_COMPLETE = 2'd3
    } state_e;

    state_e             state_q, state_d;

    logic [BIN_W-1:0]   addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [BIN_W-1:0]   tag_q, tag_d;
    logic [PWR_W-1:0]   peak_q, peak_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   maxbin_q, maxbin_d;
    logic [PWR_W-1:0]   peakpwr_q, peakpwr_d;
    logic               detect_q, detect_d;
    logic               nosig_q, nosig_d;

    logic               start_c;

    // ---------------------------------------------------------------------
    // Squared magnitude of the current RAM word.
    // Products are formed in 27 bits: (-8192)^2 = 2^26 overflows a signed
    // 27-bit result, but the bit pattern is the correct unsigned square.
    // ---------------------------------------------------------------------
    logic signed [CMP_W-1:0] re_s, im_s;
    logic signed [SQ_W-1:0]  re_prod, im_prod;
    logic        [SQ_W-1:0]  re_sq, im_sq;
    logic        [PWR_W-1:0] mag_c;

    always_comb begin
        re_s    = signed'(ramq1[27:14]);
        im_s    = signed'(ramq1[13:0]);
        re_prod = SQ_W'(re_s) * SQ_W'(re_s);
        im_prod = SQ_W'(im_s) * SQ_W'(im_s);
        re_sq   = unsigned'(re_prod);
        im_sq   = unsigned'(im_prod);
        mag_c   = PWR_W'(re_sq) + PWR_W'(im_sq);
    end

    // A new frame is accepted only while idle or holding a result.
    assign start_c = fftdone && ((state_q == S_IDLE) || (state_q == S_COMPLETE));

    // ---------------------------------------------------------------------
    // Running peak tracker: cleared on frame start, updated on strictly
    // greater qualified samples so that ties keep the earlier (lower) bin.
    // ---------------------------------------------------------------------
    always_comb begin
        peak_d = peak_q;
        bin_d  = bin_q;
        if (start_c) begin
            peak_d = '0;
            bin_d  = LOBIN;
        end else if (valid_q && (mag_c > peak_q)) begin
            peak_d = mag_c;
            bin_d  = tag_q;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. DRAIN decides on the peak including the HIBIN sample.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fftdone) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (addr_q == HIBIN) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (peak_d >= MINPWR) state_d = S_COMPLETE;
                else                  state_d = S_IDLE;
            end
            S_COMPLETE: begin
                if (fftdone) state_d = S_SCAN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (next values of the registered address, qualifiers and
    // result outputs)
    // ---------------------------------------------------------------------
    always_comb begin
        addr_d    = addr_q;
        valid_d   = 1'b0;
        tag_d     = addr_q;
        maxbin_d  = maxbin_q;
        peakpwr_d = peakpwr_q;
        detect_d  = 1'b0;
        nosig_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                addr_d = (state_d == S_SCAN) ? LOBIN : '0;
            end
            S_SCAN: begin
                valid_d = 1'b1;
                // Hold HIBIN through DRAIN; the counter never wraps.
                if (state_d == S_SCAN) addr_d = addr_q + BIN_W'(1);
            end
            S_DRAIN: begin
                if (state_d == S_COMPLETE) begin
                    maxbin_d  = bin_d;
                    peakpwr_d = peak_d;
                    detect_d  = 1'b1;
                    addr_d    = bin_d;
                end else begin
                    nosig_d   = 1'b1;
                    addr_d    = '0;
                end
            end
            S_COMPLETE: begin
                // Park the address on the peak so the beamformer reads it.
                addr_d = (state_d == S_SCAN) ? LOBIN : maxbin_q;
            end
            default: addr_d = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            valid_q   <= 1'b0;
            tag_q     <= '0;
            peak_q    <= '0;
            bin_q     <= '0;
            maxbin_q  <= '0;
            peakpwr_q <= '0;
            detect_q  <= 1'b0;
            nosig_q   <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            peak_q    <= peak_d;
            bin_q     <= bin_d;
            maxbin_q  <= maxbin_d;
            peakpwr_q <= peakpwr_d;
            detect_q  <= detect_d;
            nosig_q   <= nosig_d;
        end
    end

    assign rdaddr1    = addr_q;
    assign maxbin     = maxbin_q;
    assign peakpwr    = peakpwr_q;
    assign detectdone = detect_q;
    assign nosignal   = nosig_q;

    // Result pulses are exclusive and only follow a DRAIN cycle.
    a_pulse_excl: assert property (@(posedge clk) !(detect_q && nosig_q));
    a_pulse_after_drain: assert property (@(posedge clk) disable iff (reset)
        (detect_q || nosig_q) |-> ($past(state_q) == S_DRAIN));

endmodule
